// File: rtl/dmem_responder_206.sv
// dmem_responder_206
// MEM-stage data-memory responder. It owns a single-port word array of
// 2**(ADDR_W-2) 32-bit words and sits behind a small circular store buffer,
// so the pipeline does not wait for stores to be written. Loads are answered
// one cycle after acceptance. A load whose word has a pending store is held
// off until that store has drained.
//
// Optional feature: define DMEM_FWD_EN to forward a pending word store to a
// matching load. Forwarding only happens when the youngest matching entry is
// a word store. Without the macro, any matching entry stalls the load.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready is combinational)
//   req_wr, req_byte     store/load select, byte/word store select
//   req_addr, req_wdata  byte address, store data (byte stores use [7:0])
//   rsp_valid            one-cycle pulse, the cycle after a load is accepted
//   rsp_rdata, rsp_byte  loaded word, and the byte lane addressed by the load
//   buf_empty            registered store-buffer-empty flag (fence indicator)
module dmem_responder_206 #(
  parameter int ADDR_W    = 12,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [7:0]        rsp_byte,
  output logic              buf_empty
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      r_mem      [WORDS];

  logic [IDX_W-1:0] r_buf_idx  [BUF_DEPTH];
  logic             r_buf_byte [BUF_DEPTH];
  logic [1:0]       r_buf_lane [BUF_DEPTH];
  logic [31:0]      r_buf_data [BUF_DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic [7:0]       r_rsp_byte;
  logic             r_buf_empty;

  logic [IDX_W-1:0] w_req_idx;
  logic [PTR_W-1:0] w_scan_pos;
  logic             w_match;
  logic             w_hazard;
  logic             w_load_acc;
  logic             w_store_acc;
  logic             w_drain;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_load_word;
`ifdef DMEM_FWD_EN
  logic             w_young_byte;
  logic [31:0]      w_young_data;
  logic             w_fwd;
`endif

  assign w_req_idx = req_addr[ADDR_W-1:2];

  // Scan the valid entries from oldest to youngest. A later match overwrites
  // an earlier one, so the youngest matching entry wins.
  always_comb begin
    w_match    = 1'b0;
    w_scan_pos = '0;
`ifdef DMEM_FWD_EN
    w_young_byte = 1'b0;
    w_young_data = '0;
`endif
    for (int unsigned k = 0; k < BUF_DEPTH; k++) begin
      w_scan_pos = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_buf_idx[w_scan_pos] == w_req_idx)) begin
        w_match = 1'b1;
`ifdef DMEM_FWD_EN
        w_young_byte = r_buf_byte[w_scan_pos];
        w_young_data = r_buf_data[w_scan_pos];
`endif
      end
    end
  end

`ifdef DMEM_FWD_EN
  assign w_fwd       = w_match & ~w_young_byte;
  assign w_hazard    = w_match & w_young_byte;
  assign w_load_word = w_fwd ? w_young_data : r_mem[w_req_idx];
`else
  assign w_hazard    = w_match;
  assign w_load_word = r_mem[w_req_idx];
`endif

  // A store is gated only by the registered count. A drain in the same cycle
  // does not let a store into a full buffer.
  assign req_ready   = req_wr ? (r_count < CNT_W'(BUF_DEPTH)) : ~w_hazard;
  assign w_load_acc  = req_valid & ~req_wr & req_ready;
  assign w_store_acc = req_valid &  req_wr & req_ready;
  // The array port goes to an accepted load first; otherwise the head drains.
  assign w_drain     = ~w_load_acc & (r_count != '0);
  assign w_count_nxt = r_count + CNT_W'(w_store_acc) - CNT_W'(w_drain);

  // The array is not reset. While reset is asserted, r_count is 0, so no
  // drain can write.
  always_ff @(posedge clk) begin
    if (w_drain) begin
      if (r_buf_byte[r_head])
        r_mem[r_buf_idx[r_head]][{r_buf_lane[r_head], 3'b000} +: 8] <= r_buf_data[r_head][7:0];
      else
        r_mem[r_buf_idx[r_head]] <= r_buf_data[r_head];
    end
  end

  // Entry payloads need no reset; r_count decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_store_acc) begin
      r_buf_idx[r_tail]  <= w_req_idx;
      r_buf_byte[r_tail] <= req_byte;
      r_buf_lane[r_tail] <= req_addr[1:0];
      r_buf_data[r_tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_byte  <= '0;
      r_buf_empty <= 1'b1;
    end else begin
      if (w_store_acc) r_tail <= r_tail + 1'b1;
      if (w_drain)     r_head <= r_head + 1'b1;
      r_count     <= w_count_nxt;
      r_buf_empty <= (w_count_nxt == '0);
      r_rsp_valid <= w_load_acc;
      if (w_load_acc) begin
        r_rsp_rdata <= w_load_word;
        r_rsp_byte  <= w_load_word[{req_addr[1:0], 3'b000} +: 8];
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_byte  = r_rsp_byte;
  assign buf_empty = r_buf_empty;

endmodule

// File: tb/tb_dmem_responder_206.sv
// Testbench for dmem_responder_206. The reference model keeps the pending
// stores as a queue and the memory as a plain array. Per cycle, an accepted
// load uses the array; otherwise the oldest queued store is applied.
module tb_dmem_responder_206;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic        req_byte = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_byte;
  logic        buf_empty;

  always #5 clk = ~clk;

  dmem_responder_206 #(.ADDR_W(12), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_byte(rsp_byte),
    .buf_empty(buf_empty)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned idx;
    bit          byt;
    bit [1:0]    lane;
    bit [31:0]   data;
  } st_t;

  st_t       q[$];
  bit [31:0] m_mem   [1024];
  bit        m_known [1024];

  // Expected values from the model, and values observed on the DUT.
  bit        e_ready, e_acc, e_rsp_valid, e_known, e_empty;
  bit [31:0] e_rdata;
  bit [7:0]  e_byte;
  logic        o_ready, o_rsp_valid, o_empty;
  logic [31:0] o_rdata;
  logic [7:0]  o_byte;

  // Drive one request for one clock and advance the model.
  task automatic cyc(input bit v, input bit wr, input bit by,
                     input bit [11:0] a, input bit [31:0] d);
    int unsigned idx;
    bit hz, fwd;
    bit [31:0] fd;
    @(negedge clk);
    req_valid = v; req_wr = wr; req_byte = by; req_addr = a; req_wdata = d;
    idx = int'(a[11:2]); hz = 0; fwd = 0; fd = '0;
    if (wr) e_ready = (q.size() < 4);
    else begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].idx == idx) begin
`ifdef DMEM_FWD_EN
          fwd = !q[i].byt; hz = q[i].byt; fd = q[i].data;
`else
          hz = 1;
`endif
        end
      end
      e_ready = !hz;
    end
    #1 o_ready = req_ready;
    @(posedge clk);
    e_acc = v && e_ready;
    e_rsp_valid = 0;
    if (e_acc && !wr) begin
      e_rsp_valid = 1;
      e_rdata = fwd ? fd : m_mem[idx];
      e_known = fwd || m_known[idx];
      e_byte  = e_rdata[{a[1:0], 3'b000} +: 8];
    end else if (q.size() > 0) begin
      st_t s;
      s = q.pop_front();
      if (s.byt) m_mem[s.idx][{s.lane, 3'b000} +: 8] = s.data[7:0];
      else begin m_mem[s.idx] = s.data; m_known[s.idx] = 1; end
    end
    if (e_acc && wr) q.push_back('{idx, by, a[1:0], d});
    e_empty = (q.size() == 0);
    #1;
    o_rsp_valid = rsp_valid; o_rdata = rsp_rdata; o_byte = rsp_byte; o_empty = buf_empty;
    req_valid = 0;
  endtask

  task automatic model_reset();
    q.delete();
    e_rsp_valid = 0; e_rdata = '0; e_byte = '0; e_empty = 1; e_known = 1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_byte !== 8'h0) begin errors++; $display("FAIL reset_rsp_byte got %h want 0", rsp_byte); end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL reset_buf_empty got %0b want 1", buf_empty); end
    req_wr = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_store_ready got %0b want 1", req_ready); end
    req_wr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    bit done = 0;
    cyc(1, 1, 0, 12'h010, 32'hDEADBEEF);
    for (int n = 0; n < 8 && !done; n++) begin
      cyc(1, 0, 0, 12'h010, '0);
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL sl_ready got %0b want %0b", o_ready, e_ready); end
      checks++; if (o_empty !== e_empty) begin errors++; $display("FAIL sl_empty got %0b want %0b", o_empty, e_empty); end
      done = e_acc;
    end
    if (!done) begin errors++; $display("FAIL sl_timeout load never accepted"); end
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL sl_rsp_valid got %0b want 1", o_rsp_valid); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_rdata got %h want deadbeef", o_rdata); end
    cyc(0, 0, 0, '0, '0);
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_pulse got %0b want 0", o_rsp_valid); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_hold got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_byte_store();
    bit done = 0;
    cyc(1, 1, 0, 12'h010, 32'h11223344);
    cyc(1, 1, 1, 12'h013, 32'h5A5A5AAA);
    for (int n = 0; n < 8 && !done; n++) begin
      cyc(1, 0, 0, 12'h013, '0);
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL bs_ready got %0b want %0b", o_ready, e_ready); end
      done = e_acc;
    end
    if (!done) begin errors++; $display("FAIL bs_timeout load never accepted"); end
    checks++; if (o_rdata !== 32'hAA223344) begin errors++; $display("FAIL bs_rdata got %h want aa223344", o_rdata); end
    checks++; if (o_byte !== 8'hAA) begin errors++; $display("FAIL bs_byte got %h want aa", o_byte); end
  endtask

  task automatic test_fwd();
    bit done = 0;
    cyc(1, 1, 0, 12'h020, 32'h12345678);
    cyc(1, 0, 0, 12'h020, '0);
`ifdef DMEM_FWD_EN
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fwd_first_ready got %0b want 1", o_ready); end
`else
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fwd_first_ready got %0b want 0", o_ready); end
`endif
    done = e_acc;
    for (int n = 0; n < 8 && !done; n++) begin
      cyc(1, 0, 0, 12'h020, '0);
      done = e_acc;
    end
    if (!done) begin errors++; $display("FAIL fwd_timeout load never accepted"); end
    checks++; if (o_rdata !== 32'h12345678) begin errors++; $display("FAIL fwd_rdata got %h want 12345678", o_rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 12'h040 + 12'(4 * i), $urandom);
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL b2b_store_ready %0d got %0b want %0b", i, o_ready, e_ready); end
      for (int j = 0; j < 2; j++) begin
        cyc(1, 0, 0, 12'h010, '0);
        checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid %0d got %0b want 1", i, o_rsp_valid); end
        checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL b2b_rdata %0d got %h want %h", i, o_rdata, e_rdata); end
        checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL b2b_no_drain %0d got %0b want 0", i, o_empty); end
      end
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, '0);
    checks++; if (o_empty !== e_empty) begin errors++; $display("FAIL b2b_final_empty got %0b want %0b", o_empty, e_empty); end
  endtask

  task automatic test_reset_pending();
    cyc(1, 1, 0, 12'h080, 32'hCAFEF00D);
    cyc(1, 0, 0, 12'h010, '0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rp_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL rp_buf_empty got %0b want 1", buf_empty); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rp_rdata got %h want 0", rsp_rdata); end
    #1 rst_n = 1'b1;
    cyc(1, 0, 0, 12'h080, '0);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rp_load_ready got %0b want 1", o_ready); end
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL rp_load_rsp got %0b want 1", o_rsp_valid); end
  endtask

  task automatic test_wrap();
    bit [31:0] vals [10];
    for (int i = 0; i < 10; i++) begin
      vals[i] = $urandom;
      cyc(1, 1, 0, 12'h100 + 12'(4 * i), vals[i]);
      cyc(0, 0, 0, '0, '0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 12'h100 + 12'(4 * i), '0);
      checks++; if (o_rsp_valid !== 1'b1 || o_rdata !== vals[i])
        begin errors++; $display("FAIL wrap_read %0d got v=%0b %h want v=1 %h", i, o_rsp_valid, o_rdata, vals[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 12'(4 * i), $urandom);
      cyc(0, 0, 0, '0, '0);
    end
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          12'($urandom_range(0, 63)), $urandom);
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready %0d got %0b want %0b", n, o_ready, e_ready); end
      checks++; if (o_rsp_valid !== e_rsp_valid) begin errors++; $display("FAIL rnd_rsp_valid %0d got %0b want %0b", n, o_rsp_valid, e_rsp_valid); end
      checks++; if (o_empty !== e_empty) begin errors++; $display("FAIL rnd_empty %0d got %0b want %0b", n, o_empty, e_empty); end
      if (e_rsp_valid && e_known) begin
        checks++; if (o_rdata !== e_rdata || o_byte !== e_byte)
          begin errors++; $display("FAIL rnd_data %0d got %h/%h want %h/%h", n, o_rdata, o_byte, e_rdata, e_byte); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_fwd();
    test_back_to_back();
    test_reset_pending();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
